// File: rtl/memory_access_stage.sv
// Memory access pipeline stage: drives the data cache, stalls upstream on misses and flushes,
// and registers write-back values. Define MEM_TIMEOUT_EN to bound cache waits (oMemError).
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iExuResult,
  input  logic [31:0] iMemData,
  input  logic        iMemValid,
  input  logic        iMemWrite,
  input  logic        iMemToReg,
  input  logic        iCacheFlush,
  input  logic [4:0]  iWriteAddr,
  input  logic        iWriteEn,
  input  logic        iHalt,
  input  logic [31:0] iCacheRdData,
  input  logic        iCacheReady,
  output logic [31:0] oCacheAddr,
  output logic [31:0] oCacheWrData,
  output logic        oCacheRe,
  output logic        oCacheWe,
  output logic        oCacheFlush,
  output logic        oMemStall,
  output logic [31:0] oForwardMem,
  output logic [31:0] oWbData,
  output logic [4:0]  oWbWriteAddr,
  output logic        oWbWriteEn,
  output logic        oWbHalt
`ifdef MEM_TIMEOUT_EN
  ,
  output logic        oMemError
`endif
);

  typedef enum logic [1:0] {StIdle, StFlush, StWait} stateT;

  stateT       stateQ, stateD;
  logic [31:0] addrQ, dataQ;
  logic        validQ, writeQ, memToRegQ, wrEnQ, haltQ;
  logic [4:0]  wrAddrQ;
  logic [31:0] wbDataQ;
  logic [4:0]  wbAddrQ;
  logic        wbEnQ, wbHaltQ;

  logic        latch, retire, stall, timeout;
  logic [31:0] retData, reqAddr, reqData;
  logic [4:0]  retAddr;
  logic        retEn, retHalt, reqFlush, reqRe, reqWe;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cntQ;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cntQ <= 8'd0;
    end else if (stateQ == StIdle || stateD == StIdle) begin
      cntQ <= 8'd0;
    end else begin
      cntQ <= cntQ + 8'd1;
    end
  end

  // Fires during the TIMEOUT_CYCLES-th FLUSH/WAIT cycle that has not completed.
  assign timeout = (stateQ != StIdle) && !iCacheReady &&
                   (cntQ == 8'(TIMEOUT_CYCLES - 1));
  assign oMemError = iRst_n & timeout;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    stateD   = stateQ;
    latch    = 1'b0;
    retire   = 1'b0;
    stall    = 1'b0;
    reqFlush = 1'b0;
    reqRe    = 1'b0;
    reqWe    = 1'b0;
    reqAddr  = 32'd0;
    reqData  = 32'd0;
    retData  = iMemToReg ? iCacheRdData : iExuResult;
    retAddr  = iWriteAddr;
    retEn    = iWriteEn;
    retHalt  = iHalt;
    unique case (stateQ)
      StIdle: begin
        if (iCacheFlush) begin
          reqFlush = 1'b1;
          if (!iCacheReady) begin
            latch  = 1'b1;
            stall  = 1'b1;
            stateD = StFlush;
          end else if (iMemValid) begin
            // Flush done at once but the access still has to be issued.
            latch  = 1'b1;
            stall  = 1'b1;
            stateD = StWait;
          end else begin
            retire = 1'b1;
          end
        end else if (iMemValid) begin
          reqAddr = iExuResult;
          reqData = iMemData;
          reqWe   = iMemWrite;
          reqRe   = !iMemWrite;
          if (!iCacheReady) begin
            latch  = 1'b1;
            stall  = 1'b1;
            stateD = StWait;
          end else begin
            retire = 1'b1;
          end
        end else begin
          retire = 1'b1;
        end
      end
      StFlush: begin
        reqFlush = 1'b1;
        stall    = 1'b1;
        if (iCacheReady) begin
          if (validQ) begin
            stateD = StWait;
          end else begin
            retire = 1'b1;
            stateD = StIdle;
          end
        end
      end
      StWait: begin
        reqAddr = addrQ;
        reqData = dataQ;
        reqWe   = writeQ;
        reqRe   = !writeQ;
        if (iCacheReady) begin
          retire = 1'b1;
          stateD = StIdle;
        end else begin
          stall = 1'b1;
        end
      end
      default: stateD = StIdle;
    endcase
    if (stateQ != StIdle) begin
      retData = memToRegQ ? iCacheRdData : addrQ;
      retAddr = wrAddrQ;
      retEn   = wrEnQ;
      retHalt = haltQ;
    end
    // An abandoned request releases upstream and retires a bubble.
    if (timeout) begin
      stall  = 1'b0;
      retire = 1'b0;
      stateD = StIdle;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stateQ    <= StIdle;
      addrQ     <= 32'd0;
      dataQ     <= 32'd0;
      validQ    <= 1'b0;
      writeQ    <= 1'b0;
      memToRegQ <= 1'b0;
      wrAddrQ   <= 5'd0;
      wrEnQ     <= 1'b0;
      haltQ     <= 1'b0;
      wbDataQ   <= 32'd0;
      wbAddrQ   <= 5'd0;
      wbEnQ     <= 1'b0;
      wbHaltQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (latch) begin
        addrQ     <= iExuResult;
        dataQ     <= iMemData;
        validQ    <= iMemValid;
        writeQ    <= iMemWrite;
        memToRegQ <= iMemToReg;
        wrAddrQ   <= iWriteAddr;
        wrEnQ     <= iWriteEn;
        haltQ     <= iHalt;
      end
      if (retire) begin
        wbDataQ <= retData;
        wbAddrQ <= retAddr;
        wbEnQ   <= retEn;
        wbHaltQ <= retHalt;
      end else begin
        wbEnQ   <= 1'b0;
        wbHaltQ <= 1'b0;
      end
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign oCacheAddr   = iRst_n ? reqAddr : 32'd0;
  assign oCacheWrData = iRst_n ? reqData : 32'd0;
  assign oCacheRe     = iRst_n & reqRe;
  assign oCacheWe     = iRst_n & reqWe;
  assign oCacheFlush  = iRst_n & reqFlush;
  assign oMemStall    = iRst_n & stall;
  assign oForwardMem  = iRst_n ? iExuResult : 32'd0;
  assign oWbData      = wbDataQ;
  assign oWbWriteAddr = wbAddrQ;
  assign oWbWriteEn   = wbEnQ;
  assign oWbHalt      = wbHaltQ;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed vector bench for memory_access_stage; define MEM_TIMEOUT_EN to also cover timeouts.
module tb_memory_access_stage;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic [31:0] iExuResult, iMemData, iCacheRdData;
  logic        iMemValid, iMemWrite, iMemToReg, iCacheFlush, iWriteEn, iHalt, iCacheReady;
  logic [4:0]  iWriteAddr;
  logic [31:0] oCacheAddr, oCacheWrData, oForwardMem, oWbData;
  logic        oCacheRe, oCacheWe, oCacheFlush, oMemStall, oWbWriteEn, oWbHalt;
  logic [4:0]  oWbWriteAddr;
`ifdef MEM_TIMEOUT_EN
  logic        oMemError;
`endif

  int nCmp = 0;
  int nErr = 0;

  memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iExuResult(iExuResult), .iMemData(iMemData),
    .iMemValid(iMemValid), .iMemWrite(iMemWrite), .iMemToReg(iMemToReg),
    .iCacheFlush(iCacheFlush), .iWriteAddr(iWriteAddr), .iWriteEn(iWriteEn), .iHalt(iHalt),
    .iCacheRdData(iCacheRdData), .iCacheReady(iCacheReady), .oCacheAddr(oCacheAddr),
    .oCacheWrData(oCacheWrData), .oCacheRe(oCacheRe), .oCacheWe(oCacheWe),
    .oCacheFlush(oCacheFlush), .oMemStall(oMemStall), .oForwardMem(oForwardMem),
    .oWbData(oWbData), .oWbWriteAddr(oWbWriteAddr), .oWbWriteEn(oWbWriteEn),
    .oWbHalt(oWbHalt)
`ifdef MEM_TIMEOUT_EN
    , .oMemError(oMemError)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] exu, data, rd;
    logic        valid, write, m2r, we, halt, ready;
    logic [4:0]  wa;
    logic        xRe, xWe, xStall;
    logic [31:0] xAddr, xWrData, xWbData;
    logic [4:0]  xWbAddr;
    logic        xWbEn, xWbHalt;
  } vecT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic idleInputs();
    iExuResult = 32'd0; iMemData = 32'd0; iCacheRdData = 32'd0;
    iMemValid = 1'b0; iMemWrite = 1'b0; iMemToReg = 1'b0; iCacheFlush = 1'b0;
    iWriteAddr = 5'd0; iWriteEn = 1'b0; iHalt = 1'b0; iCacheReady = 1'b0;
  endtask

  vecT vecs[5];

  initial begin
    //          exu           data      rd            v  w  m2r we h  rdy wa
    vecs[0] = '{32'h1234, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 5'd5,
                0, 0, 0, 32'h0, 32'h0, 32'h1234, 5'd5, 1, 0};
    vecs[1] = '{32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 1, 1, 0, 1, 5'd3,
                1, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 1, 0};
    vecs[2] = '{32'h180, 32'h77, 32'h0, 1, 1, 0, 0, 0, 1, 5'd7,
                0, 1, 0, 32'h180, 32'h77, 32'h180, 5'd7, 0, 0};
    vecs[3] = '{32'hABCD, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 5'd0,
                0, 0, 0, 32'h0, 32'h0, 32'hABCD, 5'd0, 0, 1};
    vecs[4] = '{32'h42, 32'h0, 32'hFFFF, 0, 0, 0, 1, 0, 1, 5'd4,
                0, 0, 0, 32'h0, 32'h0, 32'h42, 5'd4, 1, 0};

    // Reset: outputs low even with live inputs.
    idleInputs();
    iRst_n = 1'b0;
    iExuResult = 32'h1234; iMemValid = 1'b1; iCacheFlush = 1'b1;
    #12;
    chk("rst_fwd", oForwardMem, 32'h0);
    chk("rst_re", {31'd0, oCacheRe}, 32'h0);
    chk("rst_flush", {31'd0, oCacheFlush}, 32'h0);
    chk("rst_stall", {31'd0, oMemStall}, 32'h0);
    chk("rst_wbdata", oWbData, 32'h0);
    chk("rst_wben", {31'd0, oWbWriteEn}, 32'h0);
    idleInputs();
    iRst_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      iExuResult = vecs[i].exu; iMemData = vecs[i].data; iCacheRdData = vecs[i].rd;
      iMemValid = vecs[i].valid; iMemWrite = vecs[i].write; iMemToReg = vecs[i].m2r;
      iWriteEn = vecs[i].we; iHalt = vecs[i].halt; iCacheReady = vecs[i].ready;
      iWriteAddr = vecs[i].wa; iCacheFlush = 1'b0;
      #1;
      chk($sformatf("v%0d_re", i), {31'd0, oCacheRe}, {31'd0, vecs[i].xRe});
      chk($sformatf("v%0d_we", i), {31'd0, oCacheWe}, {31'd0, vecs[i].xWe});
      chk($sformatf("v%0d_stall", i), {31'd0, oMemStall}, {31'd0, vecs[i].xStall});
      chk($sformatf("v%0d_fwd", i), oForwardMem, vecs[i].exu);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_addr", i), oCacheAddr, vecs[i].xAddr);
        if (vecs[i].write) chk($sformatf("v%0d_wrdata", i), oCacheWrData, vecs[i].xWrData);
      end
      tick();
      chk($sformatf("v%0d_wbdata", i), oWbData, vecs[i].xWbData);
      chk($sformatf("v%0d_wbaddr", i), {27'd0, oWbWriteAddr}, {27'd0, vecs[i].xWbAddr});
      chk($sformatf("v%0d_wben", i), {31'd0, oWbWriteEn}, {31'd0, vecs[i].xWbEn});
      chk($sformatf("v%0d_wbhalt", i), {31'd0, oWbHalt}, {31'd0, vecs[i].xWbHalt});
    end

    // Store miss: ready on the fourth cycle; inputs during the wait must be ignored.
    idleInputs();
    iExuResult = 32'h200; iMemData = 32'h55; iMemValid = 1'b1; iMemWrite = 1'b1;
    iWriteAddr = 5'd9;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        iExuResult = 32'hBAD; iMemData = 32'hBAD; iMemWrite = 1'b0; iWriteAddr = 5'd1;
      end
      iCacheReady = (c == 3);
      #1;
      chk($sformatf("st_we_c%0d", c), {31'd0, oCacheWe}, 32'h1);
      chk($sformatf("st_re_c%0d", c), {31'd0, oCacheRe}, 32'h0);
      chk($sformatf("st_addr_c%0d", c), oCacheAddr, 32'h200);
      chk($sformatf("st_wrdata_c%0d", c), oCacheWrData, 32'h55);
      chk($sformatf("st_stall_c%0d", c), {31'd0, oMemStall}, {31'd0, c < 3});
      tick();
      if (c < 3) begin
        chk($sformatf("st_bubble_en_c%0d", c), {31'd0, oWbWriteEn}, 32'h0);
        chk($sformatf("st_bubble_data_c%0d", c), oWbData, 32'h42);
      end
    end
    chk("st_ret_data", oWbData, 32'h200);
    chk("st_ret_addr", {27'd0, oWbWriteAddr}, 32'd9);

    // Flush plus load: flush ready at cycle 2, load ready at cycle 4.
    idleInputs();
    iCacheFlush = 1'b1; iMemValid = 1'b1; iMemToReg = 1'b1; iExuResult = 32'h300;
    iWriteAddr = 5'd12; iWriteEn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      iCacheReady = (c == 2) || (c == 4);
      iCacheRdData = (c == 4) ? 32'hCAFEF00D : 32'h1111;
      #1;
      chk($sformatf("fl_flush_c%0d", c), {31'd0, oCacheFlush}, {31'd0, c <= 2});
      chk($sformatf("fl_re_c%0d", c), {31'd0, oCacheRe}, {31'd0, c >= 3});
      chk($sformatf("fl_stall_c%0d", c), {31'd0, oMemStall}, {31'd0, c < 4});
      if (c >= 3) chk($sformatf("fl_addr_c%0d", c), oCacheAddr, 32'h300);
      tick();
      if (c < 4) chk($sformatf("fl_bubble_c%0d", c), {31'd0, oWbWriteEn}, 32'h0);
    end
    chk("fl_ret_data", oWbData, 32'hCAFEF00D);
    chk("fl_ret_addr", {27'd0, oWbWriteAddr}, 32'd12);
    chk("fl_ret_en", {31'd0, oWbWriteEn}, 32'h1);
    idleInputs();
    iExuResult = 32'h99; iWriteEn = 1'b1; iWriteAddr = 5'd1;
    #1;
    chk("fl_after_stall", {31'd0, oMemStall}, 32'h0);
    tick();
    chk("fl_after_wb", oWbData, 32'h99);

    // Reset pulse while waiting on a load.
    idleInputs();
    iExuResult = 32'h400; iMemValid = 1'b1; iMemToReg = 1'b1; iWriteEn = 1'b1;
    iWriteAddr = 5'd6;
    tick();
    #1;
    chk("rw_re_wait", {31'd0, oCacheRe}, 32'h1);
    iRst_n = 1'b0;
    #1;
    chk("rw_re", {31'd0, oCacheRe}, 32'h0);
    chk("rw_addr", oCacheAddr, 32'h0);
    chk("rw_stall", {31'd0, oMemStall}, 32'h0);
    chk("rw_wbdata", oWbData, 32'h0);
    chk("rw_wben", {31'd0, oWbWriteEn}, 32'h0);
    @(negedge iClk);
    iRst_n = 1'b1;
    idleInputs();
    iExuResult = 32'h77; iWriteEn = 1'b1; iWriteAddr = 5'd2; iCacheReady = 1'b1;
    iCacheRdData = 32'h5555;
    #1;
    chk("rw_idle_re", {31'd0, oCacheRe}, 32'h0);
    tick();
    chk("rw_first_wb", oWbData, 32'h77);
    chk("rw_first_addr", {27'd0, oWbWriteAddr}, 32'd2);

`ifdef MEM_TIMEOUT_EN
    // Timeout with the limit at 4: error pulse in cycle 4, then idle.
    idleInputs();
    iExuResult = 32'h500; iMemValid = 1'b1; iWriteEn = 1'b1; iWriteAddr = 5'd8;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("to_err_c%0d", c), {31'd0, oMemError}, {31'd0, c == 4});
      tick();
      if (c == 0) idleInputs();
      chk($sformatf("to_bubble_c%0d", c), {31'd0, oWbWriteEn}, 32'h0);
    end
    #1;
    chk("to_after_stall", {31'd0, oMemStall}, 32'h0);
    chk("to_after_err", {31'd0, oMemError}, 32'h0);
    chk("to_after_re", {31'd0, oCacheRe}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, cache-wait limit in cycles (used only with MEM_TIMEOUT_EN; legal range 1-255).
REQ-002 SHALL have ports, in the order below (name  direction  width  meaning):
- iClk  in  1  clock; all state updates on the rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iExuResult  in  32  ALU result or load/store address from the execution stage.
- iMemData  in  32  store data from the execution stage.
- iMemValid  in  1  memory operation present.
- iMemWrite  in  1  1=store, 0=load; meaningful only with iMemValid.
- iMemToReg  in  1  write-back selects load data.
- iCacheFlush  in  1  data-cache flush request.
- iWriteAddr  in  5  destination register.
- iWriteEn  in  1  register write enable.
- iHalt  in  1  halt marker.
- iCacheRdData  in  32  cache read data; valid with iCacheReady.
- iCacheReady  in  1  cache completes the current request this cycle.
- oCacheAddr  out  32  cache address.
- oCacheWrData  out  32  cache write data.
- oCacheRe  out  1  cache read request.
- oCacheWe  out  1  cache write request.
- oCacheFlush  out  1  cache flush request.
- oMemStall  out  1  freezes all upstream stages.
- oForwardMem  out  32  forwarding value for the execution stage (equals iExuResult).
- oWbData  out  32  registered write-back data.
- oWbWriteAddr  out  5  registered destination register.
- oWbWriteEn  out  1  registered write enable.
- oWbHalt  out  1  registered halt marker.
- oMemError  out  1  timeout pulse; present only with MEM_TIMEOUT_EN.

Function
REQ-003 SHALL implement FSM states IDLE, FLUSH, WAIT; reset state IDLE.
REQ-004 IDLE, iCacheFlush=1: oCacheFlush=1 combinationally; if iCacheReady=0, latch all inputs and go to FLUSH.
REQ-005 IDLE, iCacheFlush=0, iMemValid=1:
- drive oCacheAddr=iExuResult, oCacheWrData=iMemData, oCacheWe=iMemWrite, oCacheRe=!iMemWrite, all combinationally;
- if iCacheReady=0, latch all inputs and go to WAIT.
REQ-006 FLUSH: hold oCacheFlush=1 until iCacheReady=1. On completion:
- latched iMemValid=1 -> issue the access from the latched values and enter WAIT;
- otherwise retire the instruction and return to IDLE.
REQ-007 WAIT: drive requests from the latched values; on iCacheReady=1, retire and return to IDLE.
REQ-008 oMemStall SHALL equal (flush or access request active) AND NOT iCacheReady, plus 1 in every FLUSH cycle; so a same-cycle hit costs zero stall cycles.
REQ-009 Retire SHALL load the write-back registers on that edge:
- oWbData = iMemToReg ? iCacheRdData : iExuResult (latched values used when retiring from FLUSH or WAIT);
- oWbWriteAddr, oWbWriteEn, oWbHalt take the instruction's values.
REQ-010 Non-memory instruction SHALL retire on every non-stalled edge: 1-cycle latency.
REQ-011 Any edge with oMemStall=1 SHALL load a bubble: oWbWriteEn=0, oWbHalt=0; oWbData and oWbWriteAddr hold.
REQ-012 In FLUSH and WAIT, the iMem*/iCache* inputs other than iCacheReady and iCacheRdData SHALL be ignored.
REQ-013 iCacheReady while no request is active SHALL be ignored.

Reset
REQ-014 iRst_n=0 SHALL asynchronously force IDLE, clear latched state and the timeout counter, and drive all outputs to 0; an in-flight request SHALL be dropped without retirement.
REQ-015 The first edge after release SHALL behave as IDLE.

Configuration
REQ-016 With MEM_TIMEOUT_EN defined:
- an 8-bit counter counts FLUSH/WAIT cycles;
- at TIMEOUT_CYCLES it SHALL pulse oMemError for 1 cycle, retire a bubble, and return to IDLE.
REQ-017 Without MEM_TIMEOUT_EN: no counter, no oMemError port, and waits are unbounded.

Verification
REQ-018 ALU op: iExuResult=0x1234, iWriteEn=1, iWriteAddr=5, iMemValid=0 -> next edge oWbData=0x1234, oWbWriteAddr=5, oWbWriteEn=1, oMemStall=0.
REQ-019 Load hit: addr 0x100, iMemToReg=1, iCacheReady=1 same cycle, rdata 0xDEADBEEF -> oCacheRe=1, no stall, next edge oWbData=0xDEADBEEF.
REQ-020 Store miss: addr 0x200, data 0x55, ready after 3 cycles -> oCacheWe=1 held 4 cycles, oMemStall=1 for 3 cycles, 3 bubbles, then retire.
REQ-021 Flush plus load: iCacheFlush=1 and load addr 0x300 together; flush ready at cycle 2, load ready at cycle 4 -> oCacheFlush cycles 0-2, then oCacheRe with addr 0x300, retire at cycle 4.
REQ-022 Reset pulse during WAIT -> all outputs 0 immediately, state IDLE, no retirement.
REQ-023 MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and iCacheReady held 0 -> oMemError pulse at cycle 4, bubble retired, oMemStall=0 afterward.
